pk_cache_sequencer: RTL
=======================

// Module: pk_cache_sequencer
// PURPOSE
//  Controller for the public-key row cache. Streams NUM_ROWS key rows plus sums into the cache
//  over a valid/ready interface, then runs encryption passes. Each pass reads every cache row once,
//  selects rows with an internal 16-bit LFSR, and accumulates the selected rows and sums mod Q.
//  It is the only driver of the cache mode and request pins. Sits between the key loader and the
//  encryption datapath.
// PARAMETERS
//  DATA_WIDTH  12    bits per coefficient / column
//  NUM_ROWS    1024  rows per key; must match the cache instance
//  NUM_COLS    4     columns per row
//  Q           3329  modulus for all accumulation
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    reset, asynchronous, active-high; shared with the cache
//  load_start     in   1                    begin key load; accepted in IDLE or LOADED
//  key_valid      in   1                    key_row/key_sum valid
//  key_ready      out  1                    row accepted when key_valid & key_ready
//  key_row        in   NUM_COLS*DATA_WIDTH  key row
//  key_sum        in   16                   row sum
//  enc_start      in   1                    begin encryption pass; accepted in LOADED only
//  enc_seed       in   16                   LFSR seed, sampled with enc_start
//  kyber_k        in   3                    3 or 4, sampled with enc_start
//  load_done      out  1                    1-cycle pulse: key fully loaded
//  enc_done       out  1                    1-cycle pulse: acc_row/acc_sum valid
//  busy           out  1                    high in LOAD, READ, DRAIN
//  acc_row        out  NUM_COLS*DATA_WIDTH  accumulated row, mod Q per column
//  acc_sum        out  16                   accumulated sum, mod Q
//  cache_mode     out  2                    0 = write, 1 = read, 2 = idle (3 is never driven)
//  cache_kyber_k  out  3                    latched kyber_k
//  cache_enc_req  out  1                    cache read request
//  cache_row_in   out  NUM_COLS*DATA_WIDTH  = key_row (pass-through)
//  cache_sum_in   out  16                   = key_sum (pass-through)
//  cache_row_out  in   NUM_COLS*DATA_WIDTH  cache read data; registered, 1 cycle after request
//  cache_sum_out  in   16                   cache read sum; same timing as cache_row_out
//  cache_full     in   1                    cache wrote its last row (monitor only)
// BEHAVIOUR
//  Reset: state = IDLE; cnt = 0; lfsr = 1; accumulators = 0.
//   Reset output values: key_ready = 0, load_done = 0, enc_done = 0, busy = 0, cache_enc_req = 0,
//   acc_* = 0, cache_mode = 2, cache_kyber_k = 4.
//  The cache writes on every cycle mode is 0, so cache_mode = 0 only when state == LOAD && key_valid.
//   In all other cases it is 2, except in READ, where it is 1.
//  IDLE/LOADED --load_start--> LOAD: cnt <= 0. If load_start and enc_start coincide in LOADED, load wins.
//  LOAD: key_ready = 1. Each handshake increments cnt. On the NUM_ROWS-th accept, go to LOADED and pulse
//   load_done on the next cycle. Gaps in key_valid are allowed and cause no cache write.
//   load_start and enc_start are ignored in LOAD; a load cannot be aborted except by rst.
//  LOADED --enc_start--> READ: latch enc_seed (0 is replaced by 16'h0001) and kyber_k. Clear acc_*.
//   Set cnt <= 0.
//  READ: cache_mode = 1 and cache_enc_req = 1 for exactly NUM_ROWS cycles.
//   Each cycle: sel = lfsr[0]; lfsr <= lfsr[0] ? (lfsr>>1) ^ 16'hB400 : lfsr>>1. Pipeline sel by one cycle
//   as sel_d with valid flag v_d.
//   After the last request, go to DRAIN (1 cycle, cache_mode = 2), then DONE.
//  Accumulate when v_d && sel_d, using the row returned 1 cycle after its request.
//   Per column, and for the sum: t = acc + in; acc <= (t >= Q) ? t - Q : t.
//   Inputs are < Q (key loader contract); 13-bit intermediate per column, 16-bit for the sum.
//  kyber_k = 3: the cache returns column 3 as zero, so acc column 3 stays 0.
//  DONE: enc_done = 1 for 1 cycle, then LOADED. acc_* hold until the next enc_start or rst.
//  Latency: enc_start sampled at edge E gives enc_done high in cycle E+NUM_ROWS+2.
//  Pointer alignment: a full load and a full pass each wrap the cache pointers back to 0.
//   Partial passes do not exist.
//  rst mid-operation: immediate return to IDLE; the key must be reloaded.
// TESTING (NUM_ROWS=8 bench)
//  rst mid-READ -> next cycle: IDLE, cache_mode=2, acc_*=0, busy=0, no enc_done
//  load 8 rows (row i: all columns = i, sum = i) with key_valid low every 2nd cycle
//   -> exactly 8 cycles with cache_mode=0; load_done pulses once; cache_full observed
//  enc_start, seed=16'h0001, k=4 -> cache_enc_req high 8 cycles; enc_done at E+10;
//   acc matches the LFSR model selection sum mod 3329
//  all rows = 3328, seed=16'hFFFF -> each column = (3328*popcount(sel)) mod 3329 per model;
//   the wrap path is exercised
//  k=3 pass -> acc_row[47:36] = 0; columns 0-2 match the model
//  enc_start during LOAD, and enc_start together with load_start in LOADED
//   -> no read requests; load proceeds

Source files
------------

// File: rtl/pk_cache_sequencer.sv
// rtl/pk_cache_sequencer.sv - public-key row cache load/encrypt sequencer
//
// Purpose: streams NUM_ROWS key rows (plus row sums) into the row cache over a
// valid/ready handshake. It then runs encryption passes. Each pass reads every
// cache row once. A 16-bit LFSR picks rows, and the picked rows and sums are
// accumulated mod Q.
//
// Ports:
//   clk, rst                     clock; asynchronous active-high reset (shared with the cache)
//   load_start                   begin key load (IDLE or LOADED)
//   key_valid/key_ready          key row handshake; key_row/key_sum carry the row
//   enc_start, enc_seed, kyber_k begin encryption pass (LOADED only); seed and k sampled here
//   load_done, enc_done          1-cycle completion pulses
//   busy                         high in LOAD, READ, DRAIN
//   acc_row, acc_sum             accumulated result, mod Q
//   cache_mode                   0 write, 1 read, 2 idle
//   cache_kyber_k, cache_enc_req cache read control
//   cache_row_in, cache_sum_in   write data (pass-through of key_row/key_sum)
//   cache_row_out, cache_sum_out cache read data, one cycle after request
//   cache_full                   cache wrote its last row (monitor only)

module pk_cache_sequencer #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_ROWS   = 1024,
  parameter int NUM_COLS   = 4,
  parameter int Q          = 3329
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_start,
  input  logic                           key_valid,
  output logic                           key_ready,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] key_row,
  input  logic [15:0]                    key_sum,
  input  logic                           enc_start,
  input  logic [15:0]                    enc_seed,
  input  logic [2:0]                     kyber_k,
  output logic                           load_done,
  output logic                           enc_done,
  output logic                           busy,
  output logic [NUM_COLS*DATA_WIDTH-1:0] acc_row,
  output logic [15:0]                    acc_sum,
  output logic [1:0]                     cache_mode,
  output logic [2:0]                     cache_kyber_k,
  output logic                           cache_enc_req,
  output logic [NUM_COLS*DATA_WIDTH-1:0] cache_row_in,
  output logic [15:0]                    cache_sum_in,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] cache_row_out,
  input  logic [15:0]                    cache_sum_out,
  input  logic                           cache_full
);

  localparam int ROW_W = NUM_COLS * DATA_WIDTH;
  localparam int CNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOADED,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic             sel_d;
  logic             v_d;
  logic             enc_go;
  logic [ROW_W-1:0] acc_row_n;
  logic [15:0]      acc_sum_n;
  logic             unused_inputs;

  // The sequencer never reacts to cache_full; the row counter is authoritative.
  assign unused_inputs = cache_full;

  assign cache_row_in = key_row;
  assign cache_sum_in = key_sum;

  // Galois right-shift LFSR, taps 16'hB400.
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  // Load takes priority over an encryption start in LOADED.
  assign enc_go = (state == S_LOADED) && enc_start && !load_start;

  function automatic logic [DATA_WIDTH-1:0] mod_add_col(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= (DATA_WIDTH + 1)'(Q))
      mod_add_col = DATA_WIDTH'(t - (DATA_WIDTH + 1)'(Q));
    else
      mod_add_col = t[DATA_WIDTH-1:0];
  endfunction

  function automatic logic [15:0] mod_add_sum(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [15:0] t;
    t = a + b;
    mod_add_sum = (t >= 16'(Q)) ? (t - 16'(Q)) : t;
  endfunction

  always_comb begin
    acc_row_n = acc_row;
    for (int c = 0; c < NUM_COLS; c++) begin
      acc_row_n[c*DATA_WIDTH +: DATA_WIDTH] =
        mod_add_col(acc_row[c*DATA_WIDTH +: DATA_WIDTH], cache_row_out[c*DATA_WIDTH +: DATA_WIDTH]);
    end
    acc_sum_n = mod_add_sum(acc_sum, cache_sum_out);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    key_ready     = 1'b0;
    busy          = 1'b0;
    cache_mode    = 2'd2;
    cache_enc_req = 1'b0;
    enc_done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) state_n = S_LOAD;
      end
      S_LOADED: begin
        if (load_start)     state_n = S_LOAD;
        else if (enc_start) state_n = S_READ;
      end
      S_LOAD: begin
        key_ready = 1'b1;
        busy      = 1'b1;
        // The cache writes on every mode-0 cycle, so only a real beat selects write.
        if (key_valid) begin
          cache_mode = 2'd0;
          if (cnt == LAST_ROW) state_n = S_LOADED;
        end
      end
      S_READ: begin
        busy          = 1'b1;
        cache_mode    = 2'd1;
        cache_enc_req = 1'b1;
        if (cnt == LAST_ROW) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        // Last read data lands this cycle; it is accumulated at the next edge.
        busy    = 1'b1;
        state_n = S_DONE;
      end
      S_DONE: begin
        enc_done = 1'b1;
        state_n  = S_LOADED;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      lfsr          <= 16'h0001;
      sel_d         <= 1'b0;
      v_d           <= 1'b0;
      load_done     <= 1'b0;
      acc_row       <= '0;
      acc_sum       <= '0;
      cache_kyber_k <= 3'd4;
    end else begin
      load_done <= (state == S_LOAD) && key_valid && (cnt == LAST_ROW);

      // cnt is 0 on entry to LOAD/READ because every other state holds it at 0.
      case (state)
        S_LOAD:  if (key_valid) cnt <= (cnt == LAST_ROW) ? '0 : cnt + 1'b1;
        S_READ:  cnt <= (cnt == LAST_ROW) ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase

      if (enc_go) begin
        lfsr          <= (enc_seed == 16'h0000) ? 16'h0001 : enc_seed;
        cache_kyber_k <= kyber_k;
      end else if (state == S_READ) begin
        lfsr <= lfsr_next;
      end

      // Selection travels with the request so it meets the registered cache data.
      v_d   <= (state == S_READ);
      sel_d <= lfsr[0];

      if (enc_go) begin
        acc_row <= '0;
        acc_sum <= '0;
      end else if (v_d && sel_d) begin
        acc_row <= acc_row_n;
        acc_sum <= acc_sum_n;
      end
    end
  end

endmodule
